// File: rtl/cm163_if.sv
// cm163_if: control, data and status bundle of one CM163 counter slice
// master drives clr_n/load_n/enp/ent/d and observes q/rco/wrap; slave is the counter
interface cm163_if #(parameter int WIDTH = 4);
  logic clr_n, load_n, enp, ent, rco, wrap;
  logic [WIDTH-1:0] d, q;
  modport master(output clr_n, load_n, enp, ent, d, input q, rco, wrap);
  modport slave(input clr_n, load_n, enp, ent, d, output q, rco, wrap);
endinterface

// File: rtl/cm163_count_reg.sv
// cm163_count_reg: 74163-style cascadable synchronous counter with registered wrap pulse
// ports: clk, rst (sync, active-high), bus (cm163_if.slave: clr_n, load_n, enp, ent, d -> q, rco, wrap)
// CM163_RCO_REG_EN: register the terminal-count compare so rco is ent gated by a flop
module cm163_count_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic clk,
  input logic rst,
  cm163_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] q, q_next;
  logic wrap, wrap_next, cnt;
  assign cnt = bus.enp & bus.ent;
  always_comb begin
    q_next = !bus.clr_n ? '0 : !bus.load_n ? bus.d : cnt ? q + WIDTH'(1) : q;
    wrap_next = bus.clr_n & bus.load_n & cnt & (q == MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      wrap <= 1'b0;
    end else begin
      q <= q_next;
      wrap <= wrap_next;
    end
  end
`ifdef CM163_RCO_REG_EN
  // tc_q tracks (q == MAX) one flop early so the compare is off the rco path
  logic tc_q;
  always_ff @(posedge clk) tc_q <= rst ? (RST_VAL == MAX) : (q_next == MAX);
  assign bus.rco = bus.ent & tc_q;
`else
  assign bus.rco = bus.ent & (q == MAX);
`endif
  assign bus.q = q;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_cm163_count_reg.sv
// tb_cm163_count_reg: model-checked directed bench for a single counter and a two-stage cascade
module tb_cm163_count_reg;
  logic clk = 0, rst = 1, cen = 0;
  int checks = 0, errors = 0;
  int m = 0, cm = 0;
  bit wm = 0, cwm = 0, live = 0;
  cm163_if #(4) bus();
  cm163_if #(4) lo();
  cm163_if #(4) hi();
  cm163_count_reg #(.WIDTH(4), .RST_VAL(4'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  cm163_count_reg #(.WIDTH(4), .RST_VAL(4'h0)) u_lo (.clk(clk), .rst(rst), .bus(lo));
  cm163_count_reg #(.WIDTH(4), .RST_VAL(4'h0)) u_hi (.clk(clk), .rst(rst), .bus(hi));
  always #5 clk = ~clk;
  assign lo.clr_n = 1'b1;
  assign lo.load_n = 1'b1;
  assign lo.ent = 1'b1;
  assign lo.enp = cen;
  assign lo.d = 4'h0;
  assign hi.clr_n = 1'b1;
  assign hi.load_n = 1'b1;
  assign hi.ent = lo.rco;
  assign hi.enp = cen;
  assign hi.d = 4'h0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m <= 0; wm <= 0; cm <= 0; cwm <= 0; live <= 1;
    end else begin
      wm <= 0;
      if (!bus.clr_n) m <= 0;
      else if (!bus.load_n) m <= int'(bus.d);
      else if (bus.enp && bus.ent) begin
        m <= (m + 1) % 16;
        wm <= (m == 15);
      end
      cwm <= cen && cm == 255;
      if (cen) cm <= (cm + 1) % 256;
    end
  end
  always @(negedge clk) if (live) begin
    chk("q", int'(bus.q), m);
    chk("rco", int'(bus.rco), int'(bus.ent && m == 15));
    chk("wrap", int'(bus.wrap), int'(wm));
    chk("cascade_q", int'({hi.q, lo.q}), cm);
    chk("cascade_rco", int'(hi.rco), int'(cm == 255));
    chk("cascade_wrap", int'(hi.wrap), int'(cwm));
  end
  task automatic cyc(input bit r, c, l, p, t, input logic [3:0] dd);
    rst = r; bus.clr_n = c; bus.load_n = l; bus.enp = p; bus.ent = t; bus.d = dd;
    @(negedge clk);
    #1;
  endtask
  initial begin
    bus.clr_n = 1; bus.load_n = 1; bus.enp = 1; bus.ent = 1; bus.d = 4'h0;
    @(negedge clk);
    #1;
    chk("lit_reset_q", int'(bus.q), 0);
    cyc(0, 1, 0, 0, 0, 4'h9);
    chk("lit_load9", int'(bus.q), 9);
    cyc(1, 1, 1, 1, 1, 4'h0);
    chk("lit_rst_q", int'(bus.q), 0);
    chk("lit_rst_wrap", int'(bus.wrap), 0);
    chk("lit_rst_rco", int'(bus.rco), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 1, 1, 1, 4'h0);
      chk("lit_count", int'(bus.q), i);
    end
    cyc(0, 1, 0, 0, 0, 4'hD);
    cyc(0, 1, 1, 1, 1, 4'h0);
    chk("lit_E", int'(bus.q), 14);
    chk("lit_E_rco", int'(bus.rco), 0);
    cyc(0, 1, 1, 1, 1, 4'h0);
    chk("lit_F", int'(bus.q), 15);
    chk("lit_F_rco", int'(bus.rco), 1);
    chk("lit_F_wrap", int'(bus.wrap), 0);
    cyc(0, 1, 1, 1, 1, 4'h0);
    chk("lit_0", int'(bus.q), 0);
    chk("lit_0_wrap", int'(bus.wrap), 1);
    chk("lit_0_rco", int'(bus.rco), 0);
    cyc(0, 1, 1, 1, 1, 4'h0);
    chk("lit_1_wrap", int'(bus.wrap), 0);
    cyc(0, 1, 0, 0, 0, 4'hF);
    cyc(0, 1, 1, 0, 1, 4'h0);
    chk("lit_hold_q", int'(bus.q), 15);
    chk("lit_hold_rco", int'(bus.rco), 1);
    cyc(0, 1, 1, 0, 0, 4'h0);
    chk("lit_ent0_q", int'(bus.q), 15);
    chk("lit_ent0_rco", int'(bus.rco), 0);
    cyc(0, 1, 1, 1, 1, 4'h0);
    chk("lit_loadmax_wrap", int'(bus.wrap), 1);
    cyc(0, 1, 0, 0, 0, 4'h7);
    cyc(0, 0, 0, 1, 1, 4'h5);
    chk("lit_clr_wins", int'(bus.q), 0);
    chk("lit_clr_wrap", int'(bus.wrap), 0);
    cyc(0, 1, 0, 0, 0, 4'hF);
    cyc(1, 1, 1, 1, 1, 4'h0);
    chk("lit_rst_at_max_wrap", int'(bus.wrap), 0);
    cen = 1;
    repeat (255) cyc(0, 1, 1, 0, 0, 4'h0);
    chk("lit_cascade_FF", int'({hi.q, lo.q}), 255);
    chk("lit_cascade_rco", int'(hi.rco), 1);
    cyc(0, 1, 1, 0, 0, 4'h0);
    chk("lit_cascade_00", int'({hi.q, lo.q}), 0);
    chk("lit_cascade_wrap", int'(hi.wrap), 1);
    cen = 0;
    cyc(0, 1, 1, 0, 0, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
